pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_target_calc.sv | 36 +++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: redirect modes, FSM states, word stride.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_J      = 2'b00,
        MODE_JAL    = 2'b01,
        MODE_JR     = 2'b10,
        MODE_BRANCH = 2'b11
    } redir_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } state_e;

    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target, link address and JR alignment check.
module pc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [25:0]       jump_field,
    input  logic [15:0]       branch_off,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] link,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_STRIDE);

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] br_off;

    assign seq        = redir_pc + STEP;
    assign link       = seq + STEP;
    assign br_off     = {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};
    assign misaligned = |reg_target[1:0];

    always_comb begin
        target = seq;
        case (redir_mode_e'(mode))
            MODE_J, MODE_JAL: target = {seq[ADDR_W-1:28], jump_field, 2'b00};
            MODE_JR:          target = reg_target;
            MODE_BRANCH:      target = seq + br_off;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with optional one-instruction branch delay slot.
// Delay slot enabled by defining PC_SEQUENCER_DELAY_SLOT_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [1:0]        redir_mode,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [25:0]       jump_field,
    input  logic [15:0]       branch_off,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_STRIDE);

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;
    logic              misaligned;
    logic              jr_bad;
    logic              accept;
    logic              in_run;

    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] link_addr_nxt;
    logic              link_valid_nxt;
    logic              addr_err_nxt;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
        .mode       (redir_mode),
        .redir_pc   (redir_pc),
        .jump_field (jump_field),
        .branch_off (branch_off),
        .reg_target (reg_target),
        .target     (target),
        .link       (link),
        .misaligned (misaligned)
    );

`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    state_e            state, state_nxt;
    logic [ADDR_W-1:0] pending, pending_nxt;

    assign in_run = (state == ST_RUN);
    assign busy   = (state == ST_SLOT);
`else
    assign in_run = 1'b1;
    assign busy   = 1'b0;
`endif

    // A misaligned JR is rejected outright; it never redirects.
    assign jr_bad = (redir_mode == MODE_JR) && misaligned;
    assign accept = redir_valid && !stall && in_run && !jr_bad &&
                    ((redir_mode != MODE_BRANCH) || branch_taken);

    always_comb begin
        pc_nxt         = pc;
        link_addr_nxt  = link_addr;
        link_valid_nxt = 1'b0;
        addr_err_nxt   = 1'b0;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        state_nxt      = state;
        pending_nxt    = pending;
`endif
        if (!stall) begin
            if (in_run) begin
                pc_nxt       = pc + STEP;
                addr_err_nxt = redir_valid && jr_bad;
                if (accept) begin
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
                    pending_nxt = target;
                    state_nxt   = ST_SLOT;
`else
                    pc_nxt      = target;
`endif
                    if (redir_mode == MODE_JAL) begin
                        link_addr_nxt  = link;
                        link_valid_nxt = 1'b1;
                    end
                end
            end
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
            else begin
                pc_nxt    = pending;
                state_nxt = ST_RUN;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            link_addr  <= '0;
            link_valid <= 1'b0;
            addr_err   <= 1'b0;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
            state      <= ST_RUN;
            pending    <= '0;
`endif
        end else begin
            pc         <= pc_nxt;
            link_addr  <= link_addr_nxt;
            link_valid <= link_valid_nxt;
            addr_err   <= addr_err_nxt;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
            state      <= state_nxt;
            pending    <= pending_nxt;
`endif
        end
    end

endmodule
